// File: rtl/diff_frame_stat.sv
`default_nettype none
// ============================================================================
// Module      : diff_frame_stat
// Description : Two-stage frame-difference pipeline with a runtime threshold,
//               a selectable output mode and per-frame changed-pixel stats.
//               Sits between the frame-buffer read path and the
//               binarisation / bounding-box logic.
// Ports       :
//   clk, rst_n                     pixel clock, async active-low reset
//   data_cur, data_next            current / next frame pixel
//   per_frame_vsync/href/clken     input syncs
//   cfg_threshold                  change threshold (strict greater-than)
//   cfg_mode                       0/3 mask, 1 abs diff, 2 gated abs diff
//   cfg_min_count                  changed pixels needed to flag motion
//   post_frame_vsync/href/clken    syncs delayed 2 clk
//   post_img_data                  processed pixel, aligned with post syncs
//   frame_change_cnt               changed-pixel count of last full frame
//   motion_flag                    frame_change_cnt >= min count of that frame
//   frame_done                     1-clk pulse when the stats update
// Revision    : 1.0  initial release
// ============================================================================
module diff_frame_stat #(
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 20,
    parameter int TH_RESET = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_cur,
    input  logic [DATA_W-1:0] data_next,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] cfg_threshold,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_min_count,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] post_img_data,
    output logic [CNT_W-1:0]  frame_change_cnt,
    output logic              motion_flag,
    output logic              frame_done
);

    localparam logic [DATA_W-1:0] C_ONES    = {DATA_W{1'b1}};
    localparam logic [CNT_W-1:0]  C_CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Vsync rise detection and configuration latch.
    // r_vs_prev resets to 1 so that a reset released in the middle of a
    // frame (vsync already high) is not mistaken for a frame start; the
    // partial frame is therefore never counted or reported.
    // ------------------------------------------------------------------
    logic              r_vs_prev;
    logic              w_vs_rise;
    logic [DATA_W-1:0] r_th;
    logic [1:0]        r_mode;
    logic [CNT_W-1:0]  r_min;

    assign w_vs_rise = per_frame_vsync & ~r_vs_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_prev <= 1'b1;
            r_th      <= DATA_W'(TH_RESET);
            r_mode    <= 2'd0;
            r_min     <= '0;
        end else begin
            r_vs_prev <= per_frame_vsync;
            if (w_vs_rise) begin
                r_th   <= cfg_threshold;
                r_mode <= cfg_mode;
                r_min  <= cfg_min_count;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: absolute difference (ordered subtract, never wraps).
    // The rise pulse travels with the syncs so the FSM sees it exactly
    // when the post vsync rises.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_abs;
    logic [DATA_W-1:0] r_d1;
    logic              r_s1_vsync;
    logic              r_s1_href;
    logic              r_s1_clken;
    logic              r_s1_rise;

    assign w_abs = (data_next >= data_cur) ? (data_next - data_cur)
                                           : (data_cur - data_next);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d1       <= '0;
            r_s1_vsync <= 1'b0;
            r_s1_href  <= 1'b0;
            r_s1_clken <= 1'b0;
            r_s1_rise  <= 1'b0;
        end else begin
            r_d1       <= w_abs;
            r_s1_vsync <= per_frame_vsync;
            r_s1_href  <= per_frame_href;
            r_s1_clken <= per_frame_clken;
            r_s1_rise  <= w_vs_rise;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: threshold compare and mode select
    // ------------------------------------------------------------------
    logic              w_chg;
    logic [DATA_W-1:0] w_pix;
    logic              r_chg2;
    logic              r_s2_rise;

    assign w_chg = (r_d1 > r_th);

    always_comb begin
        w_pix = '0;
        if (r_s1_clken) begin
            case (r_mode)
                2'd1:    w_pix = r_d1;
                2'd2:    w_pix = w_chg ? r_d1 : '0;
                default: w_pix = w_chg ? C_ONES : '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_img_data    <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            r_chg2           <= 1'b0;
            r_s2_rise        <= 1'b0;
        end else begin
            post_img_data    <= w_pix;
            post_frame_vsync <= r_s1_vsync;
            post_frame_href  <= r_s1_href;
            post_frame_clken <= r_s1_clken;
            r_chg2           <= w_chg;
            r_s2_rise        <= r_s1_rise;
        end
    end

    // ------------------------------------------------------------------
    // Statistics FSM, driven by the post-stage syncs
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_hit;

    assign w_hit     = post_frame_clken & post_frame_href & r_chg2;
    assign w_cnt_inc = (w_hit && (r_cnt != C_CNT_MAX)) ? (r_cnt + CNT_W'(1)) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        frame_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_s2_rise) begin
                    w_next_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                // Entered with post vsync high, so a low level is the fall.
                if (!post_frame_vsync) begin
                    w_next_state = S_REPORT;
                end
            end
            S_REPORT: begin
                frame_done   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Stats are loaded on entry to REPORT so they change together with
    // the frame_done pulse; w_cnt_inc includes any hit in the exit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt            <= '0;
            frame_change_cnt <= '0;
            motion_flag      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && r_s2_rise) begin
                r_cnt <= '0;
            end else if (r_state == S_ACTIVE) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == S_ACTIVE && w_next_state == S_REPORT) begin
                frame_change_cnt <= w_cnt_inc;
                motion_flag      <= (w_cnt_inc >= r_min);
            end
        end
    end

endmodule
`default_nettype wire
